// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   S_IDLE / S_RUN / S_DONE : FSM state encodings (2-bit, legacy-compatible values)
//   can_accept()            : true in the states where a start request is sampled
package serial_adder_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // start is only honoured when no operation is in flight.
  function automatic logic can_accept(input logic [1:0] st);
    return (st == S_IDLE) || (st == S_DONE);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Gate-level full adder built only from 2-input NAND gates.
// Ports:
//   a, b, c : input bits (c is the carry-in)
//   s       : sum      = a ^ b ^ c
//   co      : carry-out = majority(a, b, c)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic n_ab;   // ~(a & b)
  logic n_a;
  logic n_b;
  logic x_ab;   // a ^ b
  logic n_xc;   // ~(x_ab & c)
  logic n_x;
  logic n_c;

  // Classic nine-NAND full adder: first half-adder forms a^b, second adds c.
  nand g0 (n_ab, a,    b);
  nand g1 (n_a,  a,    n_ab);
  nand g2 (n_b,  b,    n_ab);
  nand g3 (x_ab, n_a,  n_b);
  nand g4 (n_xc, x_ab, c);
  nand g5 (n_x,  x_ab, n_xc);
  nand g6 (n_c,  c,    n_xc);
  nand g7 (s,    n_x,  n_c);
  // co = (a & b) | ((a ^ b) & c)
  nand g8 (co,   n_xc, n_ab);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller around a single fa_cell.
// Operands are captured on an accepted start and processed LSB first,
// one bit per clock; the result is shifted into sum from the top.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, sampled only in IDLE or DONE
//   sub             : 0 = a+b+cin, 1 = a-b (cin ignored)
//   cin             : carry-in for add
//   a_in, b_in      : operands, captured on an accepted start
//   busy            : high while the operation runs (WIDTH cycles)
//   done            : one-cycle result-valid pulse
//   sum, cout, ovf  : result, final carry, signed overflow (held until next accept)
//   dbg_state       : current FSM state, for observation
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// controller is in IDLE or DONE. busy=1 for exactly WIDTH cycles after that
// edge; done=1 for the single cycle after the last bit. Requests during busy
// are dropped, and input changes during busy are never observed.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  fa_cell u_fa (
    .a  (areg[0]),
    .b  (breg[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && can_accept(state)) begin
            // Subtraction is a + ~b + 1, so invert b and force the carry-in.
            areg  <= a_in;
            breg  <= sub ? ~b_in : b_in;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the MSB step the carry flop still holds the carry into
            // the MSB, so overflow is formed directly from it here.
            state <= S_DONE;
            cout  <= fa_co;
            ovf   <= carry ^ fa_co;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .cin       (cin),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain arithmetic: modulo sum, carry out of WIDTH bits, signed range test.
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ci);
    logic [W:0] full;
    int         sa, sb, r, ci_eff;
    ci_eff = s ? 1 : int'(ci);
    if (s) begin
      full = {1'b0, a} - {1'b0, b};
      full = {1'b0, full[W-1:0]};
      m_cout = (a >= b);                    // no borrow
      sa = int'($signed(a)); sb = int'($signed(b));
      r  = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(ci_eff);
      m_cout = full[W];
      sa = int'($signed(a)); sb = int'($signed(b));
      r  = sa + sb + ci_eff;
    end
    m_sum = full[W-1:0];
    m_ovf = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endtask

  // ---------------- driver ----------------
  // Runs one operation; glitch >= 0 pulses start (with new operands) at that
  // RUN sample. Inputs are scrambled during RUN; they must have no effect.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ci, input int glitch);
    int lat, busy_cnt;
    bit seen;
    model(a, b, s, ci);
    @(negedge clk);
    a_in = a; b_in = b; sub = s; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0; seen = 0;
    for (int k = 0; k < W + 4 && !seen; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1; lat = k;
      end else begin
        a_in = W'($urandom); b_in = W'($urandom);
        sub  = 1'($urandom); cin  = 1'($urandom);
        start = (k == glitch);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("state_done", 32'(dbg_state), 32'(S_DONE));
    check("sum", 32'(sum), 32'(m_sum));
    check("cout", 32'(cout), 32'(m_cout));
    check("ovf", 32'(ovf), 32'(m_ovf));
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("state_idle", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_done, gap;
    bit seen;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk); rst_n = 1'b1;

    // 1. basic add with signed overflow
    do_op(8'h3C, 8'h5A, 1'b0, 1'b0, -1);
    // (sum already moved on by one idle cycle; results are held)
    check("t1_sum", 32'(sum), 32'h96);
    check("t1_cout", 32'(cout), 32'd0);
    check("t1_ovf", 32'(ovf), 32'd1);

    // 2. carry out, then carry-in into overflow
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    check("t2a_sum", 32'(sum), 32'h00);
    check("t2a_cout", 32'(cout), 32'd1);
    check("t2a_ovf", 32'(ovf), 32'd0);
    do_op(8'h7F, 8'h00, 1'b0, 1'b1, -1);
    check("t2b_sum", 32'(sum), 32'h80);
    check("t2b_cout", 32'(cout), 32'd0);
    check("t2b_ovf", 32'(ovf), 32'd1);

    // 3. subtraction (cin must be ignored)
    do_op(8'h05, 8'h07, 1'b1, 1'b1, -1);
    check("t3a_sum", 32'(sum), 32'hFE);
    check("t3a_cout", 32'(cout), 32'd0);
    check("t3a_ovf", 32'(ovf), 32'd0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, -1);
    check("t3b_sum", 32'(sum), 32'h7F);
    check("t3b_cout", 32'(cout), 32'd1);
    check("t3b_ovf", 32'(ovf), 32'd1);

    // 4. start during RUN ignored
    do_op(8'h21, 8'h13, 1'b0, 1'b0, 3);
    check("t4_sum", 32'(sum), 32'h34);

    // 5. async reset mid-RUN
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #20;
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_ovf", 32'(ovf), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk); rst_n = 1'b1;
    cnt_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) cnt_done++;
    end
    check("t5_no_done", 32'(cnt_done), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, -1);
    check("t5_after_sum", 32'(sum), 32'h02);

    // 6. start held through DONE: back-to-back accept
    @(negedge clk);
    a_in = 8'h11; b_in = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    seen = 0; gap = 0;
    for (int k = 0; k < W + 4 && !seen; k++) begin
      if (done) begin
        seen = 1; gap = k;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("t6_first_done", 32'(seen), 32'd1);
    check("t6_first_lat", 32'(gap), 32'(W));
    check("t6_first_sum", 32'(sum), 32'h33);
    a_in = 8'h40; b_in = 8'h40;     // start still high
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_b2b_busy", 32'(busy), 32'd1);
    check("t6_b2b_done", 32'(done), 32'd0);
    check("t6_b2b_sum_clr", 32'(sum), 32'd0);
    check("t6_b2b_ovf_clr", 32'(ovf), 32'd0);
    seen = 0; gap = 1;
    for (int k = 0; k < W + 4 && !seen; k++) begin
      if (done) seen = 1;
      else begin
        @(posedge clk); #1;
        gap++;
      end
    end
    check("t6_second_done", 32'(seen), 32'd1);
    check("t6_done_gap", 32'(gap), 32'(W + 1));
    check("t6_second_sum", 32'(sum), 32'h80);
    check("t6_second_ovf", 32'(ovf), 32'd1);
    check("t6_second_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // random add/sub against the model
    for (int i = 0; i < 256; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 9)) - 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
